// File: rtl/tp_mux_ctrl_if.sv
// Probe-group inputs, config/trigger strobes and test-point bank outputs of tp_mux_ctrl.
interface tp_mux_ctrl_if #(
  parameter int NGRP = 4,
  parameter int W    = 16
);
  logic [NGRP*W-1:0] GRP_DATA;
  logic              CFG_WE;
  logic [7:0]        CFG_DATA;
  logic              TRIG;
  logic [W-1:0]      TP_OUT;
  logic [W-1:0]      TP_DIR;
  logic [1:0]        GRP_ID;
  logic              TP_MARK;
  logic              FROZEN;
  logic [2:0]        STATE;

  modport slave (
    input  GRP_DATA, CFG_WE, CFG_DATA, TRIG,
    output TP_OUT, TP_DIR, GRP_ID, TP_MARK, FROZEN, STATE
  );

  modport master (
    output GRP_DATA, CFG_WE, CFG_DATA, TRIG,
    input  TP_OUT, TP_DIR, GRP_ID, TP_MARK, FROZEN, STATE
  );
endinterface

// File: rtl/tp_mux_ctrl.sv
// Test-point bank mux: drives one probe group onto the IOBUFs (static, timed scan or triggered capture).
// TP_OUT registered, 1-cycle latency from GRP_DATA; no backpressure, every input sampled each cycle.
module tp_mux_ctrl #(
  parameter int NGRP = 4,
  parameter int W    = 16
) (
  input logic          CLK,
  input logic          RST_B,
  tp_mux_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_LIVE  = 3'd1,
    S_SCAN  = 3'd2,
    S_ARMED = 3'd3,
    S_HOLD  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    dwell_q, dwell_d;
  logic [17:0]   cnt_q, cnt_d;
  logic [1:0]    grp_q, grp_d;
  logic [W-1:0]  tp_out_q, tp_out_d;
  logic          mark_q, mark_d;

  logic [W-1:0]  grp_arr [NGRP];
  logic [17:0]   p_last;
  logic [1:0]    cfg_mode, cfg_sel, grp_nxt;

  for (genvar g = 0; g < NGRP; g++) begin : g_split
    assign grp_arr[g] = bus.GRP_DATA[g*W +: W];
  end

  assign cfg_mode = bus.CFG_DATA[7:6];
  assign cfg_sel  = bus.CFG_DATA[5:4];
  assign grp_nxt  = grp_q + 2'd1;
  // Dwell period is 2^(D+2); the exponent needs 5 bits once D reaches 14.
  assign p_last   = (18'd1 << ({1'b0, dwell_q} + 5'd2)) - 18'd1;

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state_q  <= S_OFF;
      dwell_q  <= '0;
      cnt_q    <= '0;
      grp_q    <= '0;
      tp_out_q <= '0;
      mark_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      cnt_q    <= cnt_d;
      grp_q    <= grp_d;
      tp_out_q <= tp_out_d;
      mark_q   <= mark_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q;
    cnt_d    = cnt_q;
    grp_d    = grp_q;
    tp_out_d = tp_out_q;
    mark_d   = 1'b0;
    // A config write outranks trigger and dwell expiry, and aborts any hold.
    if (bus.CFG_WE) begin
      dwell_d  = bus.CFG_DATA[3:0];
      cnt_d    = '0;
      grp_d    = cfg_sel;
      tp_out_d = grp_arr[cfg_sel];
      case (cfg_mode)
        2'b00: begin
          state_d  = S_OFF;
          tp_out_d = '0;
        end
        2'b01:   state_d = S_LIVE;
        2'b10:   state_d = S_SCAN;
        default: state_d = S_ARMED;
      endcase
    end else begin
      case (state_q)
        S_OFF: begin
          tp_out_d = '0;
          cnt_d    = '0;
        end
        S_LIVE: tp_out_d = grp_arr[grp_q];
        S_SCAN: begin
          if (cnt_q >= p_last) begin
            cnt_d    = '0;
            grp_d    = grp_nxt;
            tp_out_d = grp_arr[grp_nxt];
            mark_d   = 1'b1;
          end else begin
            cnt_d    = cnt_q + 18'd1;
            tp_out_d = grp_arr[grp_q];
          end
        end
        S_ARMED: begin
          tp_out_d = grp_arr[grp_q];
          cnt_d    = '0;
          if (bus.TRIG) begin
            state_d = S_HOLD;
            mark_d  = 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt_q >= p_last) begin
            state_d  = S_ARMED;
            cnt_d    = '0;
            tp_out_d = grp_arr[grp_q];
          end else begin
            cnt_d = cnt_q + 18'd1;
          end
        end
        default: begin
          state_d  = S_OFF;
          cnt_d    = '0;
          tp_out_d = '0;
        end
      endcase
    end
  end

  assign bus.TP_OUT  = tp_out_q;
  assign bus.TP_DIR  = (state_q == S_OFF) ? '1 : '0;
  assign bus.GRP_ID  = grp_q;
  assign bus.TP_MARK = mark_q;
  assign bus.FROZEN  = (state_q == S_HOLD);
  assign bus.STATE   = state_q;
endmodule

// File: tb/tb_tp_mux_ctrl.sv
// Bench for tp_mux_ctrl: elapsed-time reference model checked every cycle, plus directed literal scenarios.
module tb_tp_mux_ctrl;
  localparam int NGRP = 4;
  localparam int W    = 16;

  logic CLK   = 1'b0;
  logic RST_B = 1'b0;

  tp_mux_ctrl_if #(.NGRP(NGRP), .W(W)) bus ();

  tp_mux_ctrl #(.NGRP(NGRP), .W(W)) dut (
    .CLK   (CLK),
    .RST_B (RST_B),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] grp_of(input int g);
    return bus.GRP_DATA[g*W +: W];
  endfunction

  task automatic set_grp(input int g, input logic [W-1:0] v);
    bus.GRP_DATA[g*W +: W] = v;
  endtask

  // Reference model: outputs derived from mode, cycles since the last config write, and hold start time.
  int           e, m_k, m_p, m_hs;
  logic [1:0]   m_mode, m_sel;
  bit           m_hold;
  logic [W-1:0] m_cap;
  logic [W-1:0] e_out;
  logic [1:0]   e_grp;
  logic         e_mark, e_frz;
  logic [2:0]   e_st;

  always @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      e = 0; m_k = 0; m_p = 4; m_hs = 0; m_mode = 2'd0; m_sel = 2'd0; m_hold = 0; m_cap = '0;
      e_out = '0; e_grp = 2'd0; e_mark = 1'b0; e_frz = 1'b0; e_st = 3'd0;
    end else begin
      e++;
      if (bus.CFG_WE) begin
        m_mode = bus.CFG_DATA[7:6];
        m_sel  = bus.CFG_DATA[5:4];
        m_p    = 1 << (int'(bus.CFG_DATA[3:0]) + 2);
        m_k    = 0;
        m_hold = 0;
      end else begin
        m_k++;
        if (m_mode == 2'd3) begin
          if (m_hold && (e - m_hs) < m_p) begin
          end else if (m_hold && (e - m_hs) == m_p) begin
            m_hold = 0;
          end else if (bus.TRIG) begin
            m_hold = 1;
            m_hs   = e;
            m_cap  = grp_of(int'(m_sel));
          end
        end
      end
      e_grp  = m_sel;
      e_mark = 1'b0;
      e_frz  = 1'b0;
      case (m_mode)
        2'd0: begin e_st = 3'd0; e_out = '0; end
        2'd1: begin e_st = 3'd1; e_out = grp_of(int'(m_sel)); end
        2'd2: begin
          e_st   = 3'd2;
          e_grp  = 2'((int'(m_sel) + m_k / m_p) % 4);
          e_out  = grp_of(int'(e_grp));
          e_mark = (m_k > 0) && (m_k % m_p == 0);
        end
        default: begin
          if (m_hold) begin
            e_st = 3'd4; e_out = m_cap; e_frz = 1'b1; e_mark = (e == m_hs);
          end else begin
            e_st = 3'd3; e_out = grp_of(int'(m_sel));
          end
        end
      endcase
    end
  end

  always @(negedge CLK) begin
    if (RST_B) begin
      chk("model_state",  32'(bus.STATE),   32'(e_st));
      chk("model_tp_out", 32'(bus.TP_OUT),  32'(e_out));
      chk("model_tp_dir", 32'(bus.TP_DIR),  (e_st == 3'd0) ? 32'hFFFF : 32'h0);
      chk("model_grp_id", 32'(bus.GRP_ID),  32'(e_grp));
      chk("model_mark",   32'(bus.TP_MARK), 32'(e_mark));
      chk("model_frozen", 32'(bus.FROZEN),  32'(e_frz));
    end
  end

  task automatic cfg(input logic [7:0] d);
    bus.CFG_WE   = 1'b1;
    bus.CFG_DATA = d;
    @(negedge CLK);
    bus.CFG_WE   = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"},  32'(bus.STATE),   32'h0);
    chk({tag, "_tp_dir"}, 32'(bus.TP_DIR),  32'hFFFF);
    chk({tag, "_tp_out"}, 32'(bus.TP_OUT),  32'h0);
    chk({tag, "_grp_id"}, 32'(bus.GRP_ID),  32'h0);
    chk({tag, "_mark"},   32'(bus.TP_MARK), 32'h0);
    chk({tag, "_frozen"}, 32'(bus.FROZEN),  32'h0);
  endtask

  logic [7:0] cfg_r;

  initial begin
    bus.GRP_DATA = '0;
    bus.CFG_WE   = 1'b0;
    bus.CFG_DATA = 8'h00;
    bus.TRIG     = 1'b0;
    repeat (3) @(negedge CLK);
    chk_reset_vals("rst");
    RST_B = 1'b1;
    repeat (4) @(negedge CLK);
    chk("idle_off_state", 32'(bus.STATE), 32'h0);
    chk("idle_off_dir",   32'(bus.TP_DIR), 32'hFFFF);

    // STATIC on group 2
    set_grp(2, 16'hA5A5);
    cfg(8'h60);
    chk("static_state",  32'(bus.STATE),  32'h1);
    chk("static_grp",    32'(bus.GRP_ID), 32'h2);
    chk("static_dir",    32'(bus.TP_DIR), 32'h0);
    chk("static_out",    32'(bus.TP_OUT), 32'hA5A5);
    set_grp(2, 16'h5A5A);
    chk("static_pre_edge", 32'(bus.TP_OUT), 32'hA5A5);
    @(negedge CLK);
    chk("static_one_edge", 32'(bus.TP_OUT), 32'h5A5A);

    // SCAN with P = 4
    for (int g = 0; g < NGRP; g++) set_grp(g, 16'(16'h1111 * (g + 1)));
    cfg(8'h80);
    for (int i = 0; i <= 16; i++) begin
      chk("scan_grp",  32'(bus.GRP_ID),  32'((i / 4) % 4));
      chk("scan_mark", 32'(bus.TP_MARK), (i > 0 && i % 4 == 0) ? 32'h1 : 32'h0);
      chk("scan_out",  32'(bus.TP_OUT),  32'(16'h1111 * ((i / 4) % 4 + 1)));
      if (i < 16) @(negedge CLK);
    end

    // CAPTURE on group 1 with P = 8
    set_grp(1, 16'h1234);
    cfg(8'hD1);
    chk("cap_armed", 32'(bus.STATE), 32'h3);
    bus.TRIG = 1'b1;
    @(negedge CLK);
    bus.TRIG = 1'b0;
    set_grp(1, 16'hFFFF);
    chk("cap_state",  32'(bus.STATE),   32'h4);
    chk("cap_out",    32'(bus.TP_OUT),  32'h1234);
    chk("cap_frozen", 32'(bus.FROZEN),  32'h1);
    chk("cap_mark",   32'(bus.TP_MARK), 32'h1);
    for (int i = 1; i < 8; i++) begin
      @(negedge CLK);
      bus.TRIG = (i == 3);
      chk("hold_out",    32'(bus.TP_OUT),  32'h1234);
      chk("hold_frozen", 32'(bus.FROZEN),  32'h1);
      chk("hold_mark",   32'(bus.TP_MARK), 32'h0);
    end
    @(negedge CLK);
    bus.TRIG = 1'b0;
    chk("rearm_state",  32'(bus.STATE),  32'h3);
    chk("rearm_out",    32'(bus.TP_OUT), 32'hFFFF);
    chk("rearm_frozen", 32'(bus.FROZEN), 32'h0);

    // Config write beats trigger in the same cycle
    bus.TRIG = 1'b1;
    cfg(8'h40);
    bus.TRIG = 1'b0;
    chk("prio_state",  32'(bus.STATE),   32'h1);
    chk("prio_frozen", 32'(bus.FROZEN),  32'h0);
    chk("prio_mark",   32'(bus.TP_MARK), 32'h0);

    // Config write aborts a hold
    cfg(8'hD1);
    bus.TRIG = 1'b1;
    @(negedge CLK);
    bus.TRIG = 1'b0;
    chk("abort_in_hold", 32'(bus.STATE), 32'h4);
    cfg(8'h00);
    chk("abort_state",  32'(bus.STATE),  32'h0);
    chk("abort_frozen", 32'(bus.FROZEN), 32'h0);
    chk("abort_dir",    32'(bus.TP_DIR), 32'hFFFF);
    chk("abort_out",    32'(bus.TP_OUT), 32'h0);

    // Randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      bus.GRP_DATA = {$urandom, $urandom};
      bus.CFG_WE   = ($urandom_range(0, 29) == 0);
      if (bus.CFG_WE) begin
        cfg_r = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 2))};
        bus.CFG_DATA = cfg_r;
      end
      bus.TRIG = ($urandom_range(0, 5) == 0);
      @(negedge CLK);
    end
    bus.CFG_WE = 1'b0;
    bus.TRIG   = 1'b0;

    // Asynchronous reset between edges while scanning
    for (int g = 0; g < NGRP; g++) set_grp(g, 16'(16'h1111 * (g + 1)));
    cfg(8'h92);
    repeat (5) @(negedge CLK);
    @(posedge CLK);
    #2 RST_B = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge CLK);
    RST_B = 1'b1;
    repeat (3) @(negedge CLK);
    chk("post_rst_off", 32'(bus.STATE), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/tp_mux_ctrl.md
TP_MUX_CTRL -- requirements
Module: tp_mux_ctrl

Interface
REQ-001 Parameter NGRP, default 4, number of probe groups competing for the test-point bank (fixed 4 in this release; GRP_ID is 2 bits).
REQ-002 Parameter W, default 16, test-point bank width.
REQ-003 CLK  input  1  single clock, all logic on rising edge.
REQ-004 RST_B  input  1  asynchronous, active-low reset.
REQ-005 GRP_DATA  input  NGRP*W  probe groups; group g occupies bits [g*W+W-1 : g*W].
REQ-006 CFG_WE  input  1  one-cycle config write strobe.
REQ-007 CFG_DATA  input  8  config word: [7:6] mode (00 OFF, 01 STATIC, 10 SCAN, 11 CAPTURE), [5:4] SEL group, [3:0] D dwell exponent.
REQ-008 TRIG  input  1  capture trigger (e.g. L1A), level sampled each cycle.
REQ-009 TP_OUT  output  W  registered data to test-point IOBUF I pins.
REQ-010 TP_DIR  output  W  IOBUF T pins; 1 = tri-state, 0 = drive.
REQ-011 GRP_ID  output  2  group currently on TP_OUT.
REQ-012 TP_MARK  output  1  one-cycle strobe on group switch or capture start.
REQ-013 FROZEN  output  1  high while a captured value is held.
REQ-014 STATE  output  3  FSM state code for monitoring.

Function
REQ-015 FSM states SHALL be OFF=0, LIVE=1, SCAN=2, ARMED=3, HOLD=4; other codes SHALL return to OFF next cycle.
REQ-016 A config register (mode, SEL, D) SHALL load on CFG_WE; at that same edge the FSM SHALL enter OFF/LIVE/SCAN/ARMED for mode 00/01/10/11, clear the dwell counter, and set GRP_ID = SEL.
REQ-017 CFG_WE SHALL take priority over TRIG and over any dwell-counter expiry in the same cycle.
REQ-018 OFF: TP_DIR = all 1, TP_OUT = 0, TP_MARK = 0, FROZEN = 0.
REQ-019 In all other states TP_DIR SHALL be all 0.
REQ-020 LIVE and ARMED: TP_OUT SHALL load group GRP_ID each edge, giving 1-cycle latency from GRP_DATA to TP_OUT.
REQ-021 Dwell period P = 2^(D+2) cycles (4 .. 131072); dwell counter SHALL be 18 bits, unsigned, and SHALL never wrap past P-1.
REQ-022 SCAN: counter increments each cycle; at count P-1 the counter SHALL clear and GRP_ID SHALL advance (3 wraps to 0). At that edge TP_OUT SHALL load the new group, and TP_MARK SHALL be 1 for that one cycle; GRP_ID and TP_OUT are always consistent.
REQ-023 ARMED: TRIG = 1 at an edge SHALL move to HOLD, load TP_OUT with the group GRP_ID value at that edge, clear the counter, set FROZEN = 1, and pulse TP_MARK for one cycle.
REQ-024 HOLD: TP_OUT SHALL be unchanged; TRIG SHALL be ignored; after P cycles in HOLD the FSM SHALL return to ARMED (FROZEN = 0, live tracking resumes at that edge).
REQ-025 In SCAN, CAPTURE and LIVE, TRIG SHALL have no effect outside ARMED.
REQ-026 A CFG_WE during HOLD SHALL abort the hold immediately (FROZEN = 0 at that edge).

Reset
REQ-027 RST_B low SHALL asynchronously force: STATE = OFF, config = 0x00, counter = 0, GRP_ID = 0, TP_OUT = 0, TP_DIR = all 1, TP_MARK = 0, FROZEN = 0.
REQ-028 After RST_B rises, the block SHALL stay in OFF until the first CFG_WE.

Verification
REQ-029 Reset: assert RST_B = 0 mid-SCAN between edges -> outputs at reset values before the next edge; TP_DIR = 0xFFFF.
REQ-030 STATIC: CFG_DATA = 0x60, group2 = 0xA5A5 -> STATE = 1, GRP_ID = 2, TP_DIR = 0x0000; group2 changed to 0x5A5A -> TP_OUT = 0x5A5A exactly one edge later.
REQ-031 SCAN: CFG_DATA = 0x80 -> GRP_ID sequence 0,1,2,3,0 with each value held 4 cycles; TP_MARK high one cycle at each switch; TP_OUT matches the GRP_ID group.
REQ-032 CAPTURE: CFG_DATA = 0xD1 (SEL 1, P = 8), group1 = 0x1234, pulse TRIG, then group1 = 0xFFFF -> TP_OUT = 0x1234 and FROZEN = 1 for 8 cycles; a second TRIG inside the hold is ignored; then STATE = 3 and TP_OUT = 0xFFFF.
REQ-033 Priority: in ARMED, CFG_WE (0x40) and TRIG in the same cycle -> STATE = LIVE, FROZEN stays 0, no TP_MARK.
REQ-034 Abort: CFG_WE = 0x00 during HOLD -> next edge STATE = 0, FROZEN = 0, TP_DIR = 0xFFFF, TP_OUT = 0.
